// File: rtl/ram_pkg.sv
// Shared widths and FSM encoding for the RAM request sequencer.
// Latency: n/a. Backpressure: n/a.
package ram_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int REQ_W      = 1 + DEF_ADDR_W + DEF_DATA_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RSP     = 3'd4
  } state_e;

  // Request entry layout is {we, addr, wdata}.
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/ram_req_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty detection.
// Latency: push at edge E is visible at dout after E (no bypass). Backpressure: full blocks push, empty blocks pop.
module ram_req_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop  && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ram_req_sequencer.sv
// Buffers read/write requests and sequences them onto a single-port RAM bus with tri-state turnaround.
// Latency: write hits RAM 2 edges after push; read response 3 edges after push (+queue wait). Backpressure: req_ready=!full, RSP holds until rsp_ready.
module ram_req_sequencer
  import ram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int EW = req_w(ADDR_W, DATA_W);

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     head_dat;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  state_e            state_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              mem_oe_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  ram_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({req_we, req_addr, req_wdata}),
    .dout  (head_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_we, head_addr, head_wdata} = head_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            mem_addr_q <= head_addr;
            if (head_we) begin
              state_q  <= WR;
              mem_we_q <= 1'b1;
              mem_oe_q <= 1'b1;
              wdata_q  <= head_wdata;
            end else begin
              state_q  <= RD_ADDR;
              mem_re_q <= 1'b1;
            end
          end
        end
        // RAM samples the bus on the edge leaving WR; release it on that same edge.
        WR: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
          mem_oe_q <= 1'b0;
        end
        RD_ADDR: begin
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          rsp_rdata_q <= mem_data;
          rsp_valid_q <= 1'b1;
          mem_re_q    <= 1'b0;
          state_q     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          mem_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data  = mem_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ram_req_sequencer.sv
// Bench for ram_req_sequencer: behavioural 16x8 RAM on the shared bus, directed vectors and a scoreboarded random mix.
module tb_ram_req_sequencer;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_addr;
  wire  [7:0] mem_data;

  int nvec = 0;
  int nerr = 0;

  ram_req_sequencer #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  // RAM model: latches its read register on the edge where re is first seen, drives the bus while re stays high.
  logic [7:0] ram [16] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h3C,
                           8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F};
  logic [7:0] sb  [16] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h3C,
                           8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F};
  logic       drv_q = 1'b0;
  logic [7:0] rd_reg = '0;
  logic       ram_drv;

  assign ram_drv  = drv_q && mem_re;
  assign mem_data = ram_drv ? rd_reg : 8'bz;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    if (mem_re && !drv_q) begin
      drv_q  <= 1'b1;
      rd_reg <= ram[mem_addr];
    end else if (!mem_re) begin
      drv_q <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Bus-protocol monitor and read scoreboard, sampled mid-cycle.
  int         we_cycles = 0;
  int         rsp_vld_cycles = 0;
  int         rsp_hs = 0;
  logic       prev_we = 1'b0;
  logic       prev_re = 1'b0;
  logic       sb_mode = 1'b0;
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (mem_we && mem_re) begin
      nerr++;
      $display("FAIL both_en: we=%b re=%b, expected never both", mem_we, mem_re);
    end
    if (!mem_we && !ram_drv && mem_data !== 8'bz) begin
      nerr++;
      $display("FAIL bus_not_z: mem_data=%h re=%b, expected z", mem_data, mem_re);
    end
    if (mem_we && $isunknown(mem_data)) begin
      nerr++;
      $display("FAIL wr_bus: mem_data=%h, expected driven", mem_data);
    end
    if ((prev_we && (mem_we || mem_re)) || (prev_re && mem_we)) begin
      nerr++;
      $display("FAIL turnaround: prev we/re=%b%b now we/re=%b%b, expected idle gap", prev_we, prev_re, mem_we, mem_re);
    end
    prev_we = mem_we;
    prev_re = mem_re;
    if (mem_we) we_cycles++;
    if (rsp_valid) rsp_vld_cycles++;
    if (rsp_valid && rsp_ready) begin
      rsp_hs++;
      if (sb_mode) begin
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL t5_extra_rsp: rdata=%h, expected no response", rsp_rdata);
        end else begin
          chk("t5_rd", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic push(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      nerr++;
      $display("FAIL push_timeout: req_ready=%b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we) sb[a] = d;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!rsp_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      nerr++;
      $display("FAIL %s_timeout: rsp_valid=%b, expected 1", nm, rsp_valid);
    end
  endtask

  task automatic get_rsp(input string nm, input logic [7:0] exp);
    rsp_ready = 1'b1;
    wait_rsp(nm);
    chk(nm, 32'(rsp_rdata), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t tbl [10];
  int   h_rsp;
  int   h_vld;
  int   h_we;
  int   n;
  logic       r_we;
  logic [3:0] r_a;
  logic [7:0] r_d;
  logic       prod_done;

  initial begin
    for (int i = 0; i < 5; i++) begin
      tbl[i]     = '{1'b1, 4'(i), 8'(8'h10 + i), 8'h00};
      tbl[5 + i] = '{1'b0, 4'(i), 8'h00, 8'(8'h10 + i)};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_mem_we",    32'(mem_we), 0);
    chk("rst_mem_re",    32'(mem_re), 0);
    chk("rst_mem_addr",  32'(mem_addr), 0);
    chk("rst_bus_z",     32'(mem_data === 8'bz), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: write 3=A5 then read it back, checking exact edge timing
    h_rsp = rsp_hs;
    push(1'b1, 4'd3, 8'hA5);
    chk("t1_no_bypass", 32'(mem_we), 0);
    @(posedge clk); #1;
    chk("t1_we",   32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 3);
    chk("t1_data", 32'(mem_data), 'hA5);
    push(1'b0, 4'd3, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_rsp_early", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_rdata", 32'(rsp_rdata), 'hA5);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_we_cycles", 32'(we_cycles), 1);
    chk("t1_rsp_pulses", 32'(rsp_hs - h_rsp), 1);

    // T2: hold a read in RSP so four writes fill the FIFO, then read all five back
    rsp_ready = 1'b0;
    push(1'b0, 4'd15, 8'h00);
    wait_rsp("t2_stall");
    for (int i = 0; i < 10; i++) begin
      push(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (i == 2) chk("t2_ready_at3", 32'(req_ready), 1);
      if (i == 3) begin
        chk("t2_full_ready", 32'(req_ready), 0);
        chk("t2_busy", 32'(busy), 1);
        get_rsp("t2_stall_rd", 8'h4F);
      end
      if (!tbl[i].we) get_rsp($sformatf("t2_rd%0d", i), tbl[i].exp);
    end

    // T3: read 7 held 10 cycles by rsp_ready=0, queued write must wait
    rsp_ready = 1'b0;
    push(1'b0, 4'd7, 8'h00);
    push(1'b1, 4'd8, 8'h99);
    wait_rsp("t3_wait");
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_vld",  32'(rsp_valid), 1);
      chk("t3_hold_data", 32'(rsp_rdata), 'h3C);
      chk("t3_no_wr",     32'(mem_we), 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_rsp_clr", 32'(rsp_valid), 0);
    chk("t3_idle_gap", 32'(mem_we), 0);
    @(posedge clk); #1;
    chk("t3_wr_start", 32'(mem_we), 1);
    chk("t3_wr_addr",  32'(mem_addr), 8);
    chk("t3_wr_data",  32'(mem_data), 'h99);
    @(posedge clk); #1;

    // T4: async reset while in RD_DATA with a write queued behind
    push(1'b0, 4'd8, 8'h00);
    push(1'b1, 4'd9, 8'h77);
    @(posedge clk); #1;
    chk("t4_in_rd_data", 32'(mem_re), 1);
    chk("t4_ram_drives", 32'(mem_data), 'h99);
    h_vld = rsp_vld_cycles;
    h_we  = we_cycles;
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_re",        32'(mem_re), 0);
    chk("t4_rst_we",        32'(mem_we), 0);
    chk("t4_rst_addr",      32'(mem_addr), 0);
    chk("t4_rst_bus_z",     32'(mem_data === 8'bz), 1);
    chk("t4_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("t4_rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("t4_rst_busy",      32'(busy), 0);
    chk("t4_rst_ready",     32'(req_ready), 1);
    #2 rst = 1'b0;
    sb[9] = 8'h49;
    repeat (8) @(posedge clk);
    #1;
    chk("t4_no_rsp",  32'(rsp_vld_cycles - h_vld), 0);
    chk("t4_flushed", 32'(we_cycles - h_we), 0);
    chk("t4_idle",    32'(busy), 0);

    // T5: random mix against the scoreboard with random response backpressure
    sb_mode = 1'b1;
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          r_we = 1'($urandom_range(0, 1));
          r_a  = 4'($urandom_range(0, 15));
          r_d  = 8'($urandom_range(0, 255));
          if (!r_we) exp_q.push_back(sb[r_a]);
          push(r_we, r_a, r_d);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    rsp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_drained", 32'(exp_q.size()), 0);
    chk("t5_idle", 32'(busy), 0);
    sb_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
